dsp_file_server: RTL and testbench

Responder side of the DSP equation file interface. It services the `file_read`, `file_write` and `file_reset` requests issued by the equation engines, and holds `NUM_FILES` independent circular word buffers in on-chip RAM. It returns `file_read_data`, `file_active` and the selected file's `rd_ptr`/`wr_ptr`. A low-priority host port preloads files before an equation runs.

---
 rtl/dsp_file_server_pkg.sv | 33 +++
 rtl/dsp_file_ram.sv | 28 ++
 rtl/dsp_file_server.sv | 218 +++++++++++++++++++++
 tb/tb_dsp_file_server.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_file_server_pkg.sv
// Shared constants for the DSP file server: FSM state encodings, request kinds,
// the request-priority ordering and the file-number width.
package dsp_file_server_pkg;

  localparam int FNUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESET = 3'd3,
    ST_HOST  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_RESET = 3'd1,
    REQ_WRITE = 3'd2,
    REQ_READ  = 3'd3,
    REQ_HOST  = 3'd4
  } req_t;

  // Highest priority first: reset, write, read, then the host port.
  function automatic req_t pick_req(input logic rst, input logic wr,
                                    input logic rd, input logic host);
    if (rst) return REQ_RESET;
    if (wr) return REQ_WRITE;
    if (rd) return REQ_READ;
    if (host) return REQ_HOST;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/dsp_file_ram.sv
// Single-port synchronous RAM holding every file's words back to back;
// read data is registered and holds while the port is idle.
module dsp_file_ram #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int WORDS = 1 << AW
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/dsp_file_server.sv
// Responder for DSP equation file requests: per-file circular buffers with
// read/write pointers and a host preload port. Error flag built with DSP_FILE_SERVER_ERR_EN.
module dsp_file_server
  import dsp_file_server_pkg::*;
#(
  parameter int dw         = 32,
  parameter int NUM_FILES  = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [FNUM_W-1:0] file_num,
  input  logic              file_read,
  input  logic              file_write,
  input  logic              file_reset,
  input  logic [dw-1:0]     file_write_data,
  output logic [dw-1:0]     file_read_data,
  output logic              file_active,
  output logic [31:0]       rd_ptr,
  output logic [31:0]       wr_ptr,
  input  logic              host_we,
  input  logic [FNUM_W-1:0] host_file,
  input  logic [dw-1:0]     host_data,
  output logic              host_ack,
  output logic              err,
  input  logic              err_clr
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int IDX_W = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int AW    = IDX_W + DEPTH_LOG2;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               sel_ok_q, sel_ok_d;
  logic [dw-1:0]      wdata_q, wdata_d;
  logic               rd_ok_q, rd_ok_d;
  logic [dw-1:0]      rdata_q, rdata_d;
  logic [PTR_W-1:0]   rd_ptr_q [NUM_FILES];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_FILES];

  logic               rd_inc, wr_inc, ptr_clr;
  logic               ram_en, ram_we;
  logic [DEPTH_LOG2-1:0] ram_ptr;
  logic [dw-1:0]      ram_rdata;
  logic               err_set;
  req_t               req;
  logic [FNUM_W-1:0]  req_file;
  logic               dsp_multi;

  logic [PTR_W-1:0]   cur_rd, cur_wr;
  logic               cur_empty, cur_full;

  assign cur_rd    = rd_ptr_q[sel_q];
  assign cur_wr    = wr_ptr_q[sel_q];
  assign cur_empty = (cur_rd == cur_wr);
  assign cur_full  = (cur_rd[DEPTH_LOG2-1:0] == cur_wr[DEPTH_LOG2-1:0]) &&
                     (cur_rd[DEPTH_LOG2] != cur_wr[DEPTH_LOG2]);

  assign req       = pick_req(file_reset, file_write, file_read, host_we);
  assign req_file  = (req == REQ_HOST) ? host_file : file_num;
  assign dsp_multi = (file_reset & file_write) | (file_reset & file_read) |
                     (file_write & file_read);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    sel_ok_d = sel_ok_q;
    wdata_d = wdata_q;
    rd_ok_d = rd_ok_q;
    rdata_d = rdata_q;
    rd_inc  = 1'b0;
    wr_inc  = 1'b0;
    ptr_clr = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_ptr = cur_rd[DEPTH_LOG2-1:0];
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = 1'b0;
        if (req != REQ_NONE) begin
          sel_d    = req_file[IDX_W-1:0];
          sel_ok_d = (int'(req_file) < NUM_FILES);
          wdata_d  = (req == REQ_HOST) ? host_data : file_write_data;
          if (!sel_ok_d || dsp_multi) err_set = 1'b1;
        end
        unique case (req)
          REQ_RESET: state_d = ST_RESET;
          REQ_WRITE: state_d = ST_WRITE;
          REQ_READ:  state_d = ST_READ;
          REQ_HOST:  state_d = ST_HOST;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_READ: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          rd_ok_d = sel_ok_q && !cur_empty;
          if (rd_ok_d) begin
            ram_en = 1'b1;
            rd_inc = 1'b1;
          end else if (sel_ok_q) begin
            err_set = 1'b1;
          end
        end else begin
          if (rd_ok_q) rdata_d = ram_rdata;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE, ST_HOST: begin
        // Host writes finish in one cycle; DSP writes keep a second busy cycle.
        if (!phase_q) begin
          ram_ptr = cur_wr[DEPTH_LOG2-1:0];
          if (sel_ok_q && !cur_full) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
            wr_inc = 1'b1;
          end else if (sel_ok_q) begin
            err_set = 1'b1;
          end
        end
        phase_d = 1'b1;
        if (phase_q || state_q == ST_HOST) state_d = ST_IDLE;
      end
      ST_RESET: begin
        phase_d = 1'b1;
        if (!phase_q) ptr_clr = sel_ok_q;
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      sel_q    <= '0;
      sel_ok_q <= 1'b0;
      wdata_q  <= '0;
      rd_ok_q  <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_FILES; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      sel_ok_q <= sel_ok_d;
      wdata_q  <= wdata_d;
      rd_ok_q  <= rd_ok_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < NUM_FILES; i++) begin
        if (sel_q == IDX_W'(i)) begin
          if (ptr_clr) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
          end else begin
            if (rd_inc) rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
            if (wr_inc) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
          end
        end
      end
    end
  end

  dsp_file_ram #(
    .DW    (dw),
    .AW    (AW),
    .WORDS (NUM_FILES << DEPTH_LOG2)
  ) u_ram (
    .clk_i   (wb_clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  ({sel_q, ram_ptr}),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  logic              fnum_ok;
  logic [IDX_W-1:0]  fnum_idx;

  assign fnum_ok        = (int'(file_num) < NUM_FILES);
  assign fnum_idx       = file_num[IDX_W-1:0];
  assign rd_ptr         = fnum_ok ? 32'(rd_ptr_q[fnum_idx]) : 32'd0;
  assign wr_ptr         = fnum_ok ? 32'(wr_ptr_q[fnum_idx]) : 32'd0;
  assign file_read_data = rdata_q;
  assign file_active    = (state_q != ST_IDLE);
  assign host_ack       = (state_q == ST_HOST);

`ifdef DSP_FILE_SERVER_ERR_EN
  logic err_q, err_d;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_clr ^ err_set;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_file_server.sv
// Directed bench for dsp_file_server built with DEPTH_LOG2 = 2 so full/wrap
// boundaries are reachable quickly; err expectations follow DSP_FILE_SERVER_ERR_EN.
module tb_dsp_file_server;

`ifdef DSP_FILE_SERVER_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [7:0]  file_num;
  logic        file_read, file_write, file_reset;
  logic [31:0] file_write_data;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [31:0] rd_ptr, wr_ptr;
  logic        host_we;
  logic [7:0]  host_file;
  logic [31:0] host_data;
  logic        host_ack;
  logic        err;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd_n1, rd_n2, data_n2;

  dsp_file_server #(
    .dw         (32),
    .NUM_FILES  (4),
    .DEPTH_LOG2 (2)
  ) dut (
    .wb_clk          (wb_clk),
    .wb_rst_n        (wb_rst_n),
    .file_num        (file_num),
    .file_read       (file_read),
    .file_write      (file_write),
    .file_reset      (file_reset),
    .file_write_data (file_write_data),
    .file_read_data  (file_read_data),
    .file_active     (file_active),
    .rd_ptr          (rd_ptr),
    .wr_ptr          (wr_ptr),
    .host_we         (host_we),
    .host_file       (host_file),
    .host_data       (host_data),
    .host_ack        (host_ack),
    .err             (err),
    .err_clr         (err_clr)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_fnum(input logic [7:0] fn);
    file_num = fn;
    #1;
  endtask

  // One DSP transaction; checks the two-cycle busy window and records the
  // selected pointers / read data seen in N+1 and N+2.
  task automatic dsp_op(input logic rs, input logic wr, input logic rd,
                        input logic [7:0] fn, input logic [31:0] wd);
    file_num = fn; file_reset = rs; file_write = wr; file_read = rd;
    file_write_data = wd;
    tick();
    file_reset = 1'b0; file_write = 1'b0; file_read = 1'b0;
    chk("active_n1", 32'(file_active), 32'd1);
    rd_n1 = rd_ptr;
    tick();
    chk("active_n2", 32'(file_active), 32'd1);
    rd_n2 = rd_ptr;
    data_n2 = file_read_data;
    tick();
    chk("active_n3", 32'(file_active), 32'd0);
    $display("dsp rs=%0d wr=%0d rd=%0d file=%0d wdata=%h : rdata=%h rd_ptr=%0d wr_ptr=%0d err=%0d",
             rs, wr, rd, fn, wd, file_read_data, rd_ptr, wr_ptr, err);
  endtask

  task automatic host_wr(input logic [7:0] hf, input logic [31:0] hd);
    int waited;
    waited = 99;
    host_we = 1'b1; host_file = hf; host_data = hd;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (host_ack) begin
        waited = i + 1;
        break;
      end
    end
    host_we = 1'b0;
    chk("host_ack_lat", 32'(waited), 32'd1);
    tick();
    chk("host_ack_drop", 32'(host_ack), 32'd0);
    chk("host_active_idle", 32'(file_active), 32'd0);
    $display("host file=%0d data=%h : ack_cycles=%0d err=%0d", hf, hd, waited, err);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  initial begin
    wb_rst_n = 1'b0;
    file_num = '0; file_read = 0; file_write = 0; file_reset = 0;
    file_write_data = '0; host_we = 0; host_file = '0; host_data = '0; err_clr = 0;
    tick(); tick();
    chk("rst_data", file_read_data, 32'd0);
    chk("rst_active", 32'(file_active), 32'd0);
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdptr", rd_ptr, 32'd0);
    chk("rst_wrptr", wr_ptr, 32'd0);
    wb_rst_n = 1'b1;
    tick();

    // Empty read of file 0 right after reset.
    dsp_op(0, 0, 1, 8'd0, 32'd0);
    chk("empty_err", 32'(err), 32'(EXP_ERR));
    chk("empty_data", file_read_data, 32'd0);
    chk("empty_rdptr", rd_ptr, 32'd0);
    clear_err();

    // Host preload of file 1, then three DSP reads.
    host_wr(8'd1, 32'h11);
    host_wr(8'd1, 32'h22);
    host_wr(8'd1, 32'h33);
    set_fnum(8'd1);
    chk("pre_wrptr", wr_ptr, 32'd3);
    chk("pre_rdptr", rd_ptr, 32'd0);
    dsp_op(0, 0, 1, 8'd1, 32'd0);
    chk("rd1_data", file_read_data, 32'h11);
    chk("rd1_ptr_n1", rd_n1, 32'd0);
    chk("rd1_ptr_n2", rd_n2, 32'd1);
    dsp_op(0, 0, 1, 8'd1, 32'd0);
    chk("rd2_data", file_read_data, 32'h22);
    chk("rd2_hold_n2", data_n2, 32'h11);
    dsp_op(0, 0, 1, 8'd1, 32'd0);
    chk("rd3_data", file_read_data, 32'h33);
    chk("f1_rdptr", rd_ptr, 32'd3);
    chk("f1_wrptr", wr_ptr, 32'd3);
    chk("f1_err", 32'(err), 32'd0);

    // Write+read together on file 0: the write wins, err flags the collision.
    dsp_op(0, 1, 1, 8'd0, 32'h77);
    chk("wr_pri_wrptr", wr_ptr, 32'd1);
    chk("wr_pri_rdptr", rd_ptr, 32'd0);
    chk("wr_pri_err", 32'(err), 32'(EXP_ERR));
    clear_err();
    dsp_op(0, 0, 1, 8'd0, 32'd0);
    chk("wr_pri_data", file_read_data, 32'h77);

    // Fill file 2 (4 words), fifth write dropped.
    for (int v = 1; v <= 5; v++) begin
      dsp_op(0, 1, 0, 8'd2, 32'(v));
      if (v == 4) begin
        chk("full_wrptr4", wr_ptr, 32'd4);
        chk("full_noerr", 32'(err), 32'd0);
      end
    end
    chk("full_err", 32'(err), 32'(EXP_ERR));
    chk("full_wrptr", wr_ptr, 32'd4);
    chk("full_rdptr", rd_ptr, 32'd0);
    clear_err();
    for (int v = 1; v <= 4; v++) begin
      dsp_op(0, 0, 1, 8'd2, 32'd0);
      chk("full_rd_data", file_read_data, 32'(v));
    end
    chk("wrap_rdptr", rd_ptr, 32'd4);
    chk("wrap_wrptr", wr_ptr, 32'd4);
    for (int v = 6; v <= 9; v++) dsp_op(0, 1, 0, 8'd2, 32'(v));
    for (int v = 6; v <= 9; v++) begin
      dsp_op(0, 0, 1, 8'd2, 32'd0);
      chk("wrap_rd_data", file_read_data, 32'(v));
    end
    chk("wrap0_rdptr", rd_ptr, 32'd0);
    chk("wrap0_wrptr", wr_ptr, 32'd0);
    chk("wrap0_err", 32'(err), 32'd0);

    // File 3 to wr_ptr = 5, then reset+write together.
    for (int v = 0; v < 4; v++) dsp_op(0, 1, 0, 8'd3, 32'hA0 + 32'(v));
    for (int v = 0; v < 4; v++) begin
      dsp_op(0, 0, 1, 8'd3, 32'd0);
      chk("f3_rd_data", file_read_data, 32'hA0 + 32'(v));
    end
    dsp_op(0, 1, 0, 8'd3, 32'hA4);
    chk("f3_wrptr5", wr_ptr, 32'd5);
    chk("f3_rdptr4", rd_ptr, 32'd4);
    dsp_op(1, 1, 0, 8'd3, 32'hBB);
    chk("rstwr_rdptr", rd_ptr, 32'd0);
    chk("rstwr_wrptr", wr_ptr, 32'd0);
    chk("rstwr_err", 32'(err), 32'(EXP_ERR));
    clear_err();
    dsp_op(0, 0, 1, 8'd3, 32'd0);
    chk("f3_empty_err", 32'(err), 32'(EXP_ERR));
    chk("f3_empty_hold", file_read_data, 32'hA3);
    clear_err();

    // Out-of-range DSP and host selectors (9 and 5 alias file 1 if truncated).
    dsp_op(0, 1, 0, 8'd9, 32'hDD);
    chk("oor_err", 32'(err), 32'(EXP_ERR));
    chk("oor_rdptr", rd_ptr, 32'd0);
    chk("oor_wrptr", wr_ptr, 32'd0);
    set_fnum(8'd1);
    chk("oor_f1_rd", rd_ptr, 32'd3);
    chk("oor_f1_wr", wr_ptr, 32'd3);
    clear_err();
    host_wr(8'd5, 32'hEE);
    chk("host_oor_err", 32'(err), 32'(EXP_ERR));
    set_fnum(8'd1);
    chk("host_oor_f1", wr_ptr, 32'd3);
    clear_err();

    // err_clr in the same cycle as a new error: set wins.
    file_num = 8'd0; file_read = 1'b1; err_clr = 1'b1;
    tick();
    file_read = 1'b0;
    tick();
    err_clr = 1'b0;
    tick();
    chk("clr_vs_set", 32'(err), 32'(EXP_ERR));
    $display("dsp read file=0 with err_clr : err=%0d", err);

    // Reset asserted in the middle of a read of file 2.
    host_wr(8'd2, 32'h55);
    set_fnum(8'd2);
    chk("mid_wrptr", wr_ptr, 32'd1);
    file_read = 1'b1;
    tick();
    file_read = 1'b0;
    chk("mid_active", 32'(file_active), 32'd1);
    wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_active", 32'(file_active), 32'd0);
    chk("mid_rst_data", file_read_data, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_ack", 32'(host_ack), 32'd0);
    chk("mid_rst_rdptr", rd_ptr, 32'd0);
    chk("mid_rst_wrptr", wr_ptr, 32'd0);
    $display("reset during read : active=%0d data=%h", file_active, file_read_data);
    tick();
    wb_rst_n = 1'b1;
    tick();
    dsp_op(0, 0, 1, 8'd2, 32'd0);
    chk("post_rst_err", 32'(err), 32'(EXP_ERR));
    chk("post_rst_data", file_read_data, 32'd0);
    chk("post_rst_rdptr", rd_ptr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
